// File: rtl/quad_decoder_if.sv
// Bus bundle between a quadrature decoder and its consumer.
// The slave side is the decoder; the master side drives the raw encoder pins.
interface quad_decoder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             ena;
    logic             enc_a;
    logic             enc_b;
    logic [WIDTH-1:0] value;
    logic             step_up;
    logic             step_dn;
    logic             err;

    modport master (
        output ena,
        output enc_a,
        output enc_b,
        input  value,
        input  step_up,
        input  step_dn,
        input  err
    );

    modport slave (
        input  ena,
        input  enc_a,
        input  enc_b,
        output value,
        output step_up,
        output step_dn,
        output err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronise, debounce and decode one A/B pair
// into a saturating count with step/error pulses. All outputs are registered.
module quad_decoder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned INCREMENT   = 1,
    parameter int unsigned RESET_VALUE = 0,
    parameter logic [1:0]  IDLE_AB     = 2'b11
) (
    input  logic           clk,
    input  logic           rst_n,
    quad_decoder_if.slave  bus
);

    localparam logic [3:0]       DEB_MAX = 4'(DEBOUNCE - 1);
    localparam logic [WIDTH:0]   INC_W   = INCREMENT[WIDTH:0];
    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    // Bit 1 is channel A, bit 0 is channel B throughout.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0][3:0] r_cnt;
    logic [1:0]      r_deb;
    logic [1:0]      r_prev;
    logic [WIDTH-1:0] r_value;
    logic            r_step_up;
    logic            r_step_dn;
    logic            r_err;

    logic [1:0][3:0] w_cnt_d;
    logic [1:0]      w_deb_d;
    logic            w_up;
    logic            w_dn;
    logic            w_bad;
    logic [WIDTH:0]  w_sum;
    logic [WIDTH-1:0] w_value_d;
    logic            w_step_up_d;
    logic            w_step_dn_d;
    logic            w_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= IDLE_AB;
            r_sync2   <= IDLE_AB;
            r_cnt     <= '0;
            r_deb     <= IDLE_AB;
            r_prev    <= IDLE_AB;
            r_value   <= RST_VAL;
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync1   <= {bus.enc_a, bus.enc_b};
            r_sync2   <= r_sync1;
            r_cnt     <= w_cnt_d;
            r_deb     <= w_deb_d;
            r_prev    <= r_deb;
            r_value   <= w_value_d;
            r_step_up <= w_step_up_d;
            r_step_dn <= w_step_dn_d;
            r_err     <= w_err_d;
        end
    end

    // A level is accepted only after DEBOUNCE consecutive differing samples.
    always_comb begin
        w_cnt_d = r_cnt;
        w_deb_d = r_deb;
        for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
                w_cnt_d[i] = 4'd0;
            end else if (r_cnt[i] == DEB_MAX) begin
                w_deb_d[i] = r_sync2[i];
                w_cnt_d[i] = 4'd0;
            end else begin
                w_cnt_d[i] = r_cnt[i] + 4'd1;
            end
        end
    end

    // Gray-code walk {A,B}: 00 -> 10 -> 11 -> 01 -> 00 is forward.
    always_comb begin
        w_up  = 1'b0;
        w_dn  = 1'b0;
        w_bad = 1'b0;
        case ({r_prev, r_deb})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up  = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_bad = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_sum       = {1'b0, r_value} + INC_W;
        w_value_d   = r_value;
        w_step_up_d = 1'b0;
        w_step_dn_d = 1'b0;
        w_err_d     = 1'b0;
        if (bus.ena) begin
            w_step_up_d = w_up;
            w_step_dn_d = w_dn;
            w_err_d     = w_bad;
            if (w_up) begin
                w_value_d = w_sum[WIDTH] ? MAX_VAL : w_sum[WIDTH-1:0];
            end else if (w_dn) begin
                w_value_d = ({1'b0, r_value} < INC_W) ? '0
                                                      : r_value - INC_W[WIDTH-1:0];
            end
        end
    end

    assign bus.value   = r_value;
    assign bus.step_up = r_step_up;
    assign bus.step_dn = r_step_dn;
    assign bus.err     = r_err;

endmodule
